// File: rtl/uart_xmt_fifo_pkg.sv
// Shared definitions for the FIFO-backed UART transmitter: command bit
// positions, parity modes and the transmit FSM state encoding.
package uart_pkg;

    localparam int CMD_PUSH  = 0;
    localparam int CMD_TXEN  = 2;
    localparam int CMD_FLUSH = 3;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Data is zero-extended to 9 bits so one helper covers every word width.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_xmt_fifo_if.sv
// Host bus seen by the transmitter: device-select/command address and write data.
interface uart_xmt_fifo_if #(
    parameter int WordSize = 8
);
    // No ready/valid pair: a command is qualified by the device nibble and
    // fires on the 0->1 transition of its AddrBus bit; DataBus must be stable
    // at the clock edge where PUSH fires. The host never waits on the block.
    logic [WordSize-1:0] DataBus;
    logic [31:0]         AddrBus;

    modport master (output DataBus, output AddrBus);
    modport slave  (input  DataBus, input  AddrBus);

endinterface

// File: rtl/uart_xmt_fifo_sync_fifo.sv
// Synchronous FIFO with wrap-around pointers; the extra pointer bit separates
// full from empty. Flush has priority over push and pop.
module sync_fifo #(
    parameter int WordSize = 8,
    parameter int Depth    = 16
) (
    input  logic                  clk,
    input  logic                  bReset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WordSize-1:0]   din,
    output logic [WordSize-1:0]   dout,
    output logic [$clog2(Depth):0] count,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(Depth);

    logic [WordSize-1:0] mem_q [Depth];
    logic [AW:0]         wr_q, wr_d, rd_q, rd_d;
    logic                do_push, do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!bReset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_q[AW-1:0]] <= din;
    end

    assign dout  = mem_q[rd_q[AW-1:0]];
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count = wr_q - rd_q;

endmodule

// File: rtl/uart_xmt_fifo.sv
// Bus-attached UART transmitter: edge-triggered commands load a FIFO that is
// serialised as START, LSB-first data, optional parity and STOP bits.
module uart_xmt_fifo
    import uart_pkg::*;
#(
    parameter int         WordSize   = 8,
    parameter int         Depth      = 16,
    parameter int         ClksPerBit = 16,
    parameter int         ParityMode = 0,
    parameter int         StopBits   = 1,
    parameter logic [3:0] DevId      = 4'h2
) (
    input  logic                    clk,
    input  logic                    bReset,
    uart_xmt_fifo_if.slave          bus,
    output logic                    Serial_out,
    output logic                    busy,
    output logic                    fifo_empty,
    output logic                    fifo_full,
    output logic [$clog2(Depth):0]  fifo_count,
    output logic                    overflow,
    output tx_state_e               dbg_state
);
    localparam int CW = $clog2(ClksPerBit);
    localparam int IW = $clog2(WordSize);

    tx_state_e           state_q, state_d;
    logic [CW-1:0]       timer_q, timer_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WordSize-1:0] shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_en_q, tx_en_d;
    logic                overflow_q, overflow_d;
    logic [2:0]          cmd_prev_q;
    logic [2:0]          cmd_now;
    logic                sel, push_fire, txen_fire, flush_fire;
    logic                pop, bit_done;
    logic [WordSize-1:0] fifo_dout;
    logic                unused_addr;

    assign sel        = (bus.AddrBus[31:28] == DevId);
    assign cmd_now    = {bus.AddrBus[CMD_FLUSH], bus.AddrBus[CMD_TXEN], bus.AddrBus[CMD_PUSH]};
    assign push_fire  = sel && cmd_now[0] && !cmd_prev_q[0];
    assign txen_fire  = sel && cmd_now[1] && !cmd_prev_q[1];
    assign flush_fire = sel && cmd_now[2] && !cmd_prev_q[2];
    assign unused_addr = ^{bus.AddrBus[27:4], bus.AddrBus[1]};

    sync_fifo #(
        .WordSize (WordSize),
        .Depth    (Depth)
    ) u_fifo (
        .clk   (clk),
        .bReset(bReset),
        .push  (push_fire),
        .pop   (pop),
        .flush (flush_fire),
        .din   (bus.DataBus),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        tx_en_d    = tx_en_q;
        overflow_d = overflow_q;
        if (flush_fire) begin
            tx_en_d    = 1'b0;
            overflow_d = 1'b0;
        end else begin
            if (txen_fire) tx_en_d = 1'b1;
            if (push_fire && fifo_full && !pop) overflow_d = 1'b1;
        end
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!bReset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_en_q    <= 1'b0;
            overflow_q <= 1'b0;
            cmd_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_en_q    <= tx_en_d;
            overflow_q <= overflow_d;
            cmd_prev_q <= cmd_now;
        end
    end

    assign bit_done = (timer_q == CW'(ClksPerBit - 1));

    always_comb begin
        state_d = state_q;
        timer_d = bit_done ? '0 : timer_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                idx_d   = '0;
                if (tx_en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    par_d   = parity_bit(9'(fifo_dout), ParityMode);
                    state_d = START;
                end
            end
            START: if (bit_done) state_d = DATA;
            DATA: begin
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IW'(WordSize - 1)) begin
                        idx_d   = '0;
                        state_d = (ParityMode != PAR_NONE) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: if (bit_done) state_d = STOP;
            STOP: begin
                // The bit index doubles as the stop-bit counter.
                if (bit_done) begin
                    if (idx_q == IW'(StopBits - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Serial_out = 1'b1;
        case (state_q)
            START:   Serial_out = 1'b0;
            DATA:    Serial_out = shift_q[0];
            PARITY:  Serial_out = par_q;
            default: Serial_out = 1'b1;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign overflow  = overflow_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_xmt_fifo.sv
// Directed bench: three transmitters on one bus (no parity / even / odd) with
// a negedge frame monitor feeding a scoreboard of expected serial frames.
module tb_uart_xmt_fifo;
    import uart_pkg::*;

    localparam int C = 4;

    logic clk = 1'b0;
    logic bReset;
    always #5 clk = ~clk;

    uart_xmt_fifo_if #(.WordSize(8)) bus ();

    logic [2:0] ser, bsy, emp, ful, ovf;
    logic [2:0] cnt0, cnt1, cnt2;
    tx_state_e  st0, st1, st2;

    uart_xmt_fifo #(.WordSize(8), .Depth(4), .ClksPerBit(C), .ParityMode(PAR_NONE),
                    .StopBits(1), .DevId(4'h2)) dut0 (
        .clk(clk), .bReset(bReset), .bus(bus), .Serial_out(ser[0]), .busy(bsy[0]),
        .fifo_empty(emp[0]), .fifo_full(ful[0]), .fifo_count(cnt0), .overflow(ovf[0]),
        .dbg_state(st0));

    uart_xmt_fifo #(.WordSize(8), .Depth(4), .ClksPerBit(C), .ParityMode(PAR_EVEN),
                    .StopBits(2), .DevId(4'h3)) dut_even (
        .clk(clk), .bReset(bReset), .bus(bus), .Serial_out(ser[1]), .busy(bsy[1]),
        .fifo_empty(emp[1]), .fifo_full(ful[1]), .fifo_count(cnt1), .overflow(ovf[1]),
        .dbg_state(st1));

    uart_xmt_fifo #(.WordSize(8), .Depth(4), .ClksPerBit(C), .ParityMode(PAR_ODD),
                    .StopBits(2), .DevId(4'h4)) dut_odd (
        .clk(clk), .bReset(bReset), .bus(bus), .Serial_out(ser[2]), .busy(bsy[2]),
        .fifo_empty(emp[2]), .fifo_full(ful[2]), .fifo_count(cnt2), .overflow(ovf[2]),
        .dbg_state(st2));

    typedef struct {
        int          dut;
        logic [15:0] bits;
        int          len;
        int          gap;
    } frame_t;

    frame_t      frm_q[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; holds the command bits for 'hold' edges, then
    // returns them to 0 for one edge so the next command sees a fresh rise.
    task automatic cmd(input logic [3:0] dev, input logic [3:0] bits,
                       input logic [7:0] data, input int hold);
        bus.AddrBus = {dev, 24'h0, bits};
        bus.DataBus = data;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.AddrBus = '0;
        @(negedge clk);
    endtask

    task automatic expect_frame(input int d, input int len, input int gap, input string tag);
        int          waited;
        frame_t      f;
        logic [15:0] exp_bits;
        waited   = 0;
        exp_bits = exp_q.pop_front();
        while (frm_q.size() == 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (frm_q.size() == 0) begin
            check({tag, "_arrive"}, frm_q.size(), 1);
        end else begin
            f = frm_q.pop_front();
            check({tag, "_dut"}, f.dut, d);
            check({tag, "_bits"}, f.bits, exp_bits);
            check({tag, "_len"}, f.len, len);
            if (gap > 0) check({tag, "_gap"}, f.gap, gap);
        end
    endtask

    // Frame monitor: samples each bit 1.5 clocks into its period.
    initial begin
        int          n[3];
        int          idle[3];
        int          start_gap[3];
        logic [15:0] bits[3];
        for (int d = 0; d < 3; d++) begin
            n[d] = 0; idle[d] = 0; start_gap[d] = 0; bits[d] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (bsy[d]) begin
                    if (n[d] == 0) start_gap[d] = idle[d];
                    if (n[d] % C == 1 && n[d] / C < 16) bits[d][n[d] / C] = ser[d];
                    n[d]++;
                end else begin
                    if (n[d] > 0) begin
                        frame_t f;
                        f.dut = d; f.bits = bits[d]; f.len = n[d]; f.gap = start_gap[d];
                        frm_q.push_back(f);
                        n[d] = 0; bits[d] = '0; idle[d] = 0;
                    end
                    idle[d]++;
                end
            end
        end
    end

    initial begin
        bus.AddrBus = '0;
        bus.DataBus = '0;
        bReset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serial", ser[0], 1);
        check("rst_busy", bsy[0], 0);
        check("rst_count", cnt0, 0);
        check("rst_empty", emp[0], 1);
        check("rst_full", ful[0], 0);
        check("rst_ovf", ovf[0], 0);
        check("rst_state", 32'(st0), 32'(IDLE));
        bReset = 1'b1;
        @(negedge clk);

        // Foreign device nibble must be ignored by all three blocks.
        cmd(4'h1, 4'b0001, 8'hAA, 1);
        cmd(4'h1, 4'b0100, 8'h00, 1);
        check("desel_cnt0", cnt0, 0);
        check("desel_cnt1", cnt1, 0);
        check("desel_cnt2", cnt2, 0);
        repeat (10) @(negedge clk);
        check("desel_busy", bsy, 3'b000);

        // Single frame, PUSH held three edges counts once.
        cmd(4'h2, 4'b0001, 8'h35, 3);
        check("single_cnt", cnt0, 1);
        cmd(4'h2, 4'b0100, 8'h00, 1);
        exp_q.push_back(16'b0000_0010_0110_1010);
        expect_frame(0, 40, -1, "frame35");
        check("single_empty", emp[0], 1);

        // Even then odd parity, two stop bits, data 0x07.
        cmd(4'h3, 4'b0001, 8'h07, 1);
        cmd(4'h3, 4'b0100, 8'h00, 1);
        exp_q.push_back(16'b0000_1110_0000_1110);
        expect_frame(1, 48, -1, "even07");
        cmd(4'h4, 4'b0001, 8'h07, 1);
        cmd(4'h4, 4'b0100, 8'h00, 1);
        exp_q.push_back(16'b0000_1100_0000_1110);
        expect_frame(2, 48, -1, "odd07");

        // Overflow with transmit disabled, then drain in order.
        cmd(4'h2, 4'b1000, 8'h00, 1);
        for (int b = 1; b <= 5; b++) cmd(4'h2, 4'b0001, 8'(b), 1);
        check("ovf_full", ful[0], 1);
        check("ovf_count", cnt0, 4);
        check("ovf_flag", ovf[0], 1);
        cmd(4'h2, 4'b0100, 8'h00, 1);
        for (int b = 1; b <= 4; b++) begin
            exp_q.push_back(16'({1'b1, 8'(b), 1'b0}));
            expect_frame(0, 40, (b > 1) ? 1 : -1, $sformatf("drain%0d", b));
        end
        check("drain_empty", emp[0], 1);

        // Flush during the first frame's data bits.
        cmd(4'h2, 4'b1000, 8'h00, 1);
        check("flush_clr_ovf", ovf[0], 0);
        for (int b = 0; b < 5; b++) cmd(4'h2, 4'b0001, 8'h11 * 8'(b + 1), 1);
        check("fl_pre_ovf", ovf[0], 1);
        cmd(4'h2, 4'b0100, 8'h00, 1);
        repeat (12) @(negedge clk);
        check("fl_in_data", 32'(st0), 32'(DATA));
        cmd(4'h2, 4'b1000, 8'h00, 1);
        check("fl_count", cnt0, 0);
        check("fl_empty", emp[0], 1);
        check("fl_ovf", ovf[0], 0);
        exp_q.push_back(16'({1'b1, 8'h11, 1'b0}));
        expect_frame(0, 40, -1, "fl_first");
        repeat (60) @(negedge clk);
        check("fl_no_more", frm_q.size(), 0);

        // Push while full on the same edge as the IDLE pop.
        for (int b = 0; b < 4; b++) cmd(4'h2, 4'b0001, 8'h0A + 8'(b), 1);
        check("sim_full_pre", ful[0], 1);
        bus.AddrBus = {4'h2, 24'h0, 4'b0100};
        @(negedge clk);
        bus.AddrBus = {4'h2, 24'h0, 4'b0101};
        bus.DataBus = 8'h0E;
        @(negedge clk);
        bus.AddrBus = '0;
        check("sim_count", cnt0, 4);
        check("sim_full", ful[0], 1);
        check("sim_ovf", ovf[0], 0);
        check("sim_busy", bsy[0], 1);
        for (int b = 0; b < 5; b++) begin
            exp_q.push_back(16'({1'b1, 8'h0A + 8'(b), 1'b0}));
            expect_frame(0, 40, (b > 0) ? 1 : -1, $sformatf("sim%0d", b));
        end

        // Reset in the middle of a frame's data bits.
        cmd(4'h2, 4'b0001, 8'h5A, 1);
        cmd(4'h2, 4'b0001, 8'hA5, 1);
        check("mid_cnt", cnt0, 1);
        repeat (4) @(negedge clk);
        check("mid_state", 32'(st0), 32'(DATA));
        bReset = 1'b0;
        @(negedge clk);
        bReset = 1'b1;
        check("mid_serial", ser[0], 1);
        check("mid_busy", bsy[0], 0);
        check("mid_count", cnt0, 0);
        check("mid_empty", emp[0], 1);
        check("mid_idle", 32'(st0), 32'(IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
